therm_n1_load_store_unit: RTL and testbench
===========================================

# therm_n1_load_store_unit

Parametrised load/store execution unit for the ThermN1 core. It sits between decode and the shared simple memory. It accepts one load or store per handshake and computes the effective address (base + sign-extended 12-bit offset). It drives byte lanes and enables on an XLEN-wide word-addressed memory port, then returns sign- or zero-extended load data for register writeback. It supports byte, half, word and double accesses, flags misaligned or illegal accesses as faults without touching memory, and stalls on memory wait states.

## Interface
Parameters:
- XLEN, 64, data/register width; 32 or 64 only.
- ADDR_WIDTH, 64, width of the effective address and `mem_address`.
- TIMEOUT_CYCLES, 255, watchdog limit (used only with the macro in Configuration).

Ports:
- clock  in  1  single clock; all state on posedge.
- reset_neg  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  [1:0] size (0 B, 1 H, 2 W, 3 D); [2] unsigned load.
- req_base  in  XLEN  rs1 value.
- req_offset  in  12  signed immediate.
- req_store_data  in  XLEN  rs2 value, low bytes significant.
- req_rd  in  5  load destination.
- mem_address  out  ADDR_WIDTH  word-aligned address; low log2(XLEN/8) bits are 0.
- mem_chip_enable  out  1  access in progress.
- mem_write_enable  out  1  store access.
- mem_byte_enable  out  XLEN/8  active byte lanes.
- mem_data_store  out  XLEN  lane-shifted store data.
- mem_data_load  in  XLEN  read word; valid when mem_ready is high.
- mem_ready  in  1  access complete this cycle.
- resp_valid  out  1  one-cycle completion pulse (loads and stores).
- resp_rd  out  5  destination; 0 for stores.
- resp_data  out  XLEN  extended load data; 0 for stores and for rd = 0.
- fault  out  1  one-cycle fault pulse, exclusive with resp_valid.
- fault_address  out  ADDR_WIDTH  effective address of the faulting request.

## Operation
- FSM states: IDLE, ACCESS, RESPOND, FAULT.
- IDLE:
  - Handshake fires on req_valid && req_ready.
  - Effective address ea = req_base + sext(req_offset), truncated to ADDR_WIDTH, wrapping modulo 2^ADDR_WIDTH.
  - lane = ea[log2(XLEN/8)-1:0].
- Fault check at acceptance:
  - ea not naturally aligned to the access size → FAULT.
  - Size D when XLEN = 32 → FAULT.
  - funct3 = 3'b111 → FAULT.
  - Store with funct3[2] = 1 → FAULT.
- Otherwise → ACCESS, with all request fields registered.
- ACCESS:
  - mem_chip_enable = 1; mem_write_enable = req_store.
  - mem_byte_enable = ((1 << (1 << size)) - 1) << lane.
  - mem_data_store = req_store_data << (8 * lane).
  - Outputs are held stable until mem_ready; then → RESPOND.
  - For loads, the extended data is captured on the mem_ready cycle:
    - raw = mem_data_load >> (8 * lane), truncated to the access size.
    - Signed loads sign-extend from bit 8·2^size − 1; unsigned loads zero-extend.
    - Size D is passed through unchanged.
- RESPOND: resp_valid = 1 for one cycle → IDLE.
- FAULT: fault = 1 and fault_address = ea for one cycle. No memory access is made. → IDLE.
- A load to rd = 0 still performs the memory access; resp_rd = 0 and resp_data = 0.
- req_valid is ignored outside IDLE.

## Timing
- Reset (reset_neg low, asynchronous): state IDLE; every output 0, including req_ready. req_ready rises in the first cycle after reset_neg goes high.
- Reset mid-ACCESS aborts the access; chip enable drops immediately and no response is produced.
- Acceptance at cycle N → mem_chip_enable from N+1.
- mem_ready seen at cycle M ≥ N+1 → resp_valid at M+1, mem_chip_enable low at M+1.
- Minimum latency 2 cycles; maximum throughput one request per 3 cycles.
- Fault: pulse at N+1; req_ready back high at N+2.
- mem_ready while not in ACCESS is ignored.

## Configuration
- THERM_N1_LSU_TIMEOUT_EN defined: an 8+-bit wait counter clears on entry to ACCESS and increments on each ACCESS cycle without mem_ready. When it reaches TIMEOUT_CYCLES, the access is abandoned: mem_chip_enable drops, the unit → FAULT, and fault_address = ea.
- Macro undefined: no counter; ACCESS waits indefinitely for mem_ready.

## Test plan
- LB, base 0x1000, offset 3, mem_data_load 0x0000_0000_8000_0000 → mem_address 0x1000, byte_enable 0x08, resp_data 0xFFFF_FFFF_FFFF_FF80; same with LBU → 0x80.
- SH, base 0x2000, offset 6, data 0x1234 → byte_enable 0xC0, mem_data_store 0x1234_0000_0000_0000, write_enable 1, resp_valid with resp_rd 0.
- LW, base 0x1000, offset 2 → fault at N+1, fault_address 0x1002, mem_chip_enable never asserted.
- LWU, base 0x100, offset 0xFFC (−4), mem_ready delayed 3 cycles, word 0xDEAD_BEEF_0000_0000 → mem_address 0xF8, resp_data 0xDEAD_BEEF at mem_ready+1.
- reset_neg low during ACCESS wait → all outputs 0 immediately, no resp_valid; req_ready high 1 cycle after release.
- With THERM_N1_LSU_TIMEOUT_EN, mem_ready held low → fault after 255 ACCESS cycles; without the macro, the unit remains in ACCESS.

Source files
------------

// File: rtl/therm_n1_load_store_unit.sv
// -----------------------------------------------------------------------------
// therm_n1_load_store_unit
//
// Load/store execution unit for the ThermN1 core. Accepts one load or store per
// req_valid/req_ready handshake, forms the effective address
// (base + sign-extended 12-bit offset), and checks alignment and encoding.
// Legal requests drive one access on a word-addressed memory port. Illegal
// requests raise a one-cycle fault pulse and never touch memory. Load data
// is returned sign- or zero-extended for register writeback.
//
// Optional feature macro: THERM_N1_LSU_TIMEOUT_EN
//   When defined, an access that sees no mem_ready for TIMEOUT_CYCLES cycles
//   is abandoned and reported as a fault at the request's effective address.
//   When undefined, the unit waits indefinitely for mem_ready.
//
// Ports
//   clock, reset_neg        clock / asynchronous active-low reset
//   req_*                   request from decode (valid/ready handshake)
//   mem_*                   word-addressed memory port (chip/write/byte enable)
//   resp_valid/rd/data      one-cycle completion pulse with writeback data
//   fault, fault_address    one-cycle fault pulse with the faulting address
// All outputs are registered.
// -----------------------------------------------------------------------------
module therm_n1_load_store_unit #(
  parameter int XLEN           = 64,
  parameter int ADDR_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset_neg,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_store,
  input  logic [2:0]              req_funct3,
  input  logic [XLEN-1:0]         req_base,
  input  logic [11:0]             req_offset,
  input  logic [XLEN-1:0]         req_store_data,
  input  logic [4:0]              req_rd,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic                    mem_chip_enable,
  output logic                    mem_write_enable,
  output logic [XLEN/8-1:0]       mem_byte_enable,
  output logic [XLEN-1:0]         mem_data_store,
  input  logic [XLEN-1:0]         mem_data_load,
  input  logic                    mem_ready,
  output logic                    resp_valid,
  output logic [4:0]              resp_rd,
  output logic [XLEN-1:0]         resp_data,
  output logic                    fault,
  output logic [ADDR_WIDTH-1:0]   fault_address
);

  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);
  localparam int SW = (XLEN > ADDR_WIDTH) ? XLEN : ADDR_WIDTH;

  if (!((XLEN == 32) || (XLEN == 64)) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
    $error("therm_n1_load_store_unit: XLEN must be 32 or 64 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2,
    FAULT   = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  next_state_s;
  logic [SW-1:0]           sum_s;
  logic [ADDR_WIDTH-1:0]   ea_s;
  logic [LW-1:0]           lane_s;
  logic [1:0]              size_s;
  logic                    misalign_s;
  logic                    illegal_s;
  logic                    accept_s;

  logic                    req_ready_r;
  logic [ADDR_WIDTH-1:0]   mem_address_r;
  logic                    mem_chip_enable_r;
  logic                    mem_write_enable_r;
  logic [NB-1:0]           mem_byte_enable_r;
  logic [XLEN-1:0]         mem_data_store_r;
  logic                    resp_valid_r;
  logic [4:0]              resp_rd_r;
  logic [XLEN-1:0]         resp_data_r;
  logic                    fault_r;
  logic [ADDR_WIDTH-1:0]   fault_address_r;

  // Request fields kept for the load-data path while the access is in flight.
  logic                    store_r;
  logic [1:0]              size_r;
  logic                    unsigned_r;
  logic [LW-1:0]           lane_r;
  logic [4:0]              rd_r;

`ifdef THERM_N1_LSU_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0]           wait_cnt_r;
  logic [ADDR_WIDTH-1:0]   ea_r;
  logic                    timeout_s;
`endif

  // Byte lanes covered by an access of 2^size bytes starting at byte lane 'lane'.
  function automatic logic [NB-1:0] lane_mask(input logic [1:0] size, input logic [LW-1:0] lane);
    logic [NB-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) begin
      m[i] = (i < (32'd1 << size));
    end
    return m << lane;
  endfunction

  // Pick the accessed bytes out of the read word and extend them to XLEN.
  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] word,
                                                  input logic [LW-1:0]   lane,
                                                  input logic [1:0]      size,
                                                  input logic            is_unsigned);
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] res;
    raw = word >> {lane, 3'b000};
    case (size)
      2'd0:    res = is_unsigned ? XLEN'(raw[7:0])  : XLEN'($signed(raw[7:0]));
      2'd1:    res = is_unsigned ? XLEN'(raw[15:0]) : XLEN'($signed(raw[15:0]));
      2'd2:    res = is_unsigned ? XLEN'(raw[31:0]) : XLEN'($signed(raw[31:0]));
      default: res = raw;
    endcase
    return res;
  endfunction

  // Effective address, legality check and next-state selection.
  always_comb begin
    sum_s    = SW'(req_base) + {{(SW-12){req_offset[11]}}, req_offset};
    ea_s     = sum_s[ADDR_WIDTH-1:0];
    lane_s   = ea_s[LW-1:0];
    size_s   = req_funct3[1:0];
    case (size_s)
      2'd0:    misalign_s = 1'b0;
      2'd1:    misalign_s = ea_s[0];
      2'd2:    misalign_s = |ea_s[1:0];
      2'd3:    misalign_s = |ea_s[2:0];
      default: misalign_s = 1'b1;
    endcase
    illegal_s = misalign_s
              | ((size_s == 2'd3) && (XLEN == 32))
              | (req_funct3 == 3'b111)
              | (req_store && req_funct3[2]);
    accept_s  = req_valid && req_ready_r && (state_r == IDLE);
`ifdef THERM_N1_LSU_TIMEOUT_EN
    // Abort on the cycle the wait counter would reach the limit.
    timeout_s = (state_r == ACCESS) && !mem_ready
              && (wait_cnt_r == CW'(TIMEOUT_CYCLES - 1));
`endif
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = illegal_s ? FAULT : ACCESS;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          next_state_s = RESPOND;
`ifdef THERM_N1_LSU_TIMEOUT_EN
        end else if (timeout_s) begin
          next_state_s = FAULT;
`endif
        end else begin
          next_state_s = ACCESS;
        end
      end
      RESPOND: next_state_s = IDLE;
      FAULT:   next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register, captured request fields and registered outputs.
  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      state_r            <= IDLE;
      req_ready_r        <= 1'b0;
      mem_address_r      <= '0;
      mem_chip_enable_r  <= 1'b0;
      mem_write_enable_r <= 1'b0;
      mem_byte_enable_r  <= '0;
      mem_data_store_r   <= '0;
      resp_valid_r       <= 1'b0;
      resp_rd_r          <= 5'd0;
      resp_data_r        <= '0;
      fault_r            <= 1'b0;
      fault_address_r    <= '0;
      store_r            <= 1'b0;
      size_r             <= 2'd0;
      unsigned_r         <= 1'b0;
      lane_r             <= '0;
      rd_r               <= 5'd0;
    end else begin
      state_r      <= next_state_s;
      req_ready_r  <= (next_state_s == IDLE);
      resp_valid_r <= (next_state_s == RESPOND);
      fault_r      <= (next_state_s == FAULT);

      if (accept_s) begin
        store_r    <= req_store;
        size_r     <= size_s;
        unsigned_r <= req_funct3[2];
        lane_r     <= lane_s;
        rd_r       <= req_rd;
      end

      // Memory port: loaded on entry to ACCESS, held while waiting, zero otherwise.
      if ((state_r == IDLE) && (next_state_s == ACCESS)) begin
        mem_chip_enable_r  <= 1'b1;
        mem_write_enable_r <= req_store;
        mem_address_r      <= {ea_s[ADDR_WIDTH-1:LW], {LW{1'b0}}};
        mem_byte_enable_r  <= lane_mask(size_s, lane_s);
        mem_data_store_r   <= req_store_data << {lane_s, 3'b000};
      end else if (next_state_s != ACCESS) begin
        mem_chip_enable_r  <= 1'b0;
        mem_write_enable_r <= 1'b0;
        mem_address_r      <= '0;
        mem_byte_enable_r  <= '0;
        mem_data_store_r   <= '0;
      end

      // Writeback data is captured on the mem_ready cycle; stores and rd = 0 return 0.
      if ((state_r == ACCESS) && mem_ready) begin
        resp_rd_r   <= store_r ? 5'd0 : rd_r;
        resp_data_r <= (store_r || (rd_r == 5'd0))
                     ? '0 : extend_load(mem_data_load, lane_r, size_r, unsigned_r);
      end else begin
        resp_rd_r   <= 5'd0;
        resp_data_r <= '0;
      end

      if ((state_r == IDLE) && (next_state_s == FAULT)) begin
        fault_address_r <= ea_s;
`ifdef THERM_N1_LSU_TIMEOUT_EN
      end else if ((state_r == ACCESS) && (next_state_s == FAULT)) begin
        fault_address_r <= ea_r;
`endif
      end else begin
        fault_address_r <= '0;
      end
    end
  end

`ifdef THERM_N1_LSU_TIMEOUT_EN
  // Wait-state counter and effective address kept for a timeout fault.
  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      wait_cnt_r <= '0;
      ea_r       <= '0;
    end else begin
      if (accept_s) begin
        ea_r <= ea_s;
      end
      if ((state_r != ACCESS) && (next_state_s == ACCESS)) begin
        wait_cnt_r <= '0;
      end else if ((state_r == ACCESS) && !mem_ready) begin
        wait_cnt_r <= wait_cnt_r + CW'(1);
      end
    end
  end
`endif

  assign req_ready        = req_ready_r;
  assign mem_address      = mem_address_r;
  assign mem_chip_enable  = mem_chip_enable_r;
  assign mem_write_enable = mem_write_enable_r;
  assign mem_byte_enable  = mem_byte_enable_r;
  assign mem_data_store   = mem_data_store_r;
  assign resp_valid       = resp_valid_r;
  assign resp_rd          = resp_rd_r;
  assign resp_data        = resp_data_r;
  assign fault            = fault_r;
  assign fault_address    = fault_address_r;

endmodule

// File: tb/tb_therm_n1_load_store_unit.sv
// -----------------------------------------------------------------------------
// Testbench for therm_n1_load_store_unit (XLEN = 64, ADDR_WIDTH = 64, default
// build). Directed cases followed by randomized requests, each checked against
// an arithmetic reference model of the load/store rules.
// -----------------------------------------------------------------------------
module tb_therm_n1_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_neg;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_base;
  logic [11:0] req_offset;
  logic [63:0] req_store_data;
  logic [4:0]  req_rd;
  logic [63:0] mem_address;
  logic        mem_chip_enable;
  logic        mem_write_enable;
  logic [7:0]  mem_byte_enable;
  logic [63:0] mem_data_store;
  logic [63:0] mem_data_load;
  logic        mem_ready;
  logic        resp_valid;
  logic [4:0]  resp_rd;
  logic [63:0] resp_data;
  logic        fault;
  logic [63:0] fault_address;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  therm_n1_load_store_unit #(
    .XLEN(64), .ADDR_WIDTH(64), .TIMEOUT_CYCLES(255)
  ) dut (
    .clock(clock), .reset_neg(reset_neg),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_store_data(req_store_data), .req_rd(req_rd),
    .mem_address(mem_address), .mem_chip_enable(mem_chip_enable),
    .mem_write_enable(mem_write_enable), .mem_byte_enable(mem_byte_enable),
    .mem_data_store(mem_data_store), .mem_data_load(mem_data_load),
    .mem_ready(mem_ready), .resp_valid(resp_valid), .resp_rd(resp_rd),
    .resp_data(resp_data), .fault(fault), .fault_address(fault_address)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on the effective address and byte counts.
  function automatic void model(input bit st, input logic [2:0] f3, input logic [63:0] base,
                                input logic [11:0] off, input logic [63:0] sdata,
                                input logic [63:0] word, output bit flt,
                                output logic [63:0] ea, output logic [63:0] addr,
                                output logic [63:0] be, output logic [63:0] sd,
                                output logic [63:0] ld);
    int unsigned nbytes;
    int unsigned lane;
    logic [63:0] raw;
    logic [63:0] mask;
    ea     = base + {{52{off[11]}}, off};
    nbytes = 1 << f3[1:0];
    lane   = int'(ea % 64'd8);
    flt    = ((ea % nbytes) != 0) || (f3 == 3'b111) || (st && f3[2]);
    addr   = ea - (ea % 64'd8);
    be     = ((64'd1 << nbytes) - 64'd1) << lane;
    sd     = sdata << (8 * lane);
    raw    = word >> (8 * lane);
    if (nbytes < 8) begin
      mask = (64'd1 << (8 * nbytes)) - 64'd1;
      raw  = raw & mask;
      if (!f3[2] && raw[8 * nbytes - 1]) raw = raw | ~mask;
    end
    ld = raw;
  endfunction

  task automatic do_txn(input bit st, input logic [2:0] f3, input logic [63:0] base,
                        input logic [11:0] off, input logic [63:0] sdata,
                        input logic [4:0] rd, input logic [63:0] word, input int nwait);
    bit          flt;
    logic [63:0] ea, addr, be, sd, ld;
    int          k;
    model(st, f3, base, off, sdata, word, flt, ea, addr, be, sd, ld);
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      @(posedge clock); #1;
      k++;
    end
    chk("ready_before_req", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_base = base;
    req_offset = off; req_store_data = sdata; req_rd = rd;
    @(posedge clock); #1;
    req_valid = 1'b0;
    if (flt) begin
      chk("fault_pulse",    {63'd0, fault}, 64'd1);
      chk("fault_address",  fault_address, ea);
      chk("fault_no_ce",    {63'd0, mem_chip_enable}, 64'd0);
      chk("fault_no_resp",  {63'd0, resp_valid}, 64'd0);
      @(posedge clock); #1;
      chk("fault_cleared",  {63'd0, fault}, 64'd0);
      chk("fault_ready",    {63'd0, req_ready}, 64'd1);
      chk("fault_ce_after", {63'd0, mem_chip_enable}, 64'd0);
    end else begin
      chk("ce_on",      {63'd0, mem_chip_enable}, 64'd1);
      chk("we",         {63'd0, mem_write_enable}, {63'd0, st});
      chk("mem_address", mem_address, addr);
      chk("byte_enable", {56'd0, mem_byte_enable}, be);
      if (st) chk("store_data", mem_data_store, sd);
      chk("busy_not_ready", {63'd0, req_ready}, 64'd0);
      for (int w = 0; w < nwait; w++) begin
        // A request presented while busy must be ignored.
        req_valid = 1'b1;
        req_base  = {$urandom, $urandom};
        @(posedge clock); #1;
      end
      req_valid = 1'b0;
      if (nwait > 0) begin
        chk("ce_held",      {63'd0, mem_chip_enable}, 64'd1);
        chk("address_held", mem_address, addr);
      end
      mem_ready = 1'b1; mem_data_load = word;
      @(posedge clock); #1;
      mem_ready = 1'b0; mem_data_load = {$urandom, $urandom};
      chk("resp_valid", {63'd0, resp_valid}, 64'd1);
      chk("ce_off",     {63'd0, mem_chip_enable}, 64'd0);
      chk("resp_rd",    {59'd0, resp_rd}, st ? 64'd0 : {59'd0, rd});
      chk("resp_data",  resp_data, (st || rd == 5'd0) ? 64'd0 : ld);
      chk("no_fault",   {63'd0, fault}, 64'd0);
      @(posedge clock); #1;
      chk("resp_pulse_end", {63'd0, resp_valid}, 64'd0);
      chk("ready_again",    {63'd0, req_ready}, 64'd1);
    end
  endtask

  initial begin
    bit          st;
    logic [2:0]  f3;
    logic [63:0] base;
    logic [11:0] off;
    logic [63:0] ea;
    int unsigned nb;

    reset_neg = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_base = 64'd0; req_offset = 12'd0; req_store_data = 64'd0; req_rd = 5'd0;
    mem_data_load = 64'd0; mem_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_ce",    {63'd0, mem_chip_enable}, 64'd0);
    chk("rst_resp",  {63'd0, resp_valid}, 64'd0);
    chk("rst_fault", {63'd0, fault}, 64'd0);
    chk("rst_addr",  mem_address, 64'd0);
    @(negedge clock);
    reset_neg = 1'b1;
    @(posedge clock); #1;
    chk("ready_after_rst", {63'd0, req_ready}, 64'd1);

    // Directed cases.
    do_txn(1'b0, 3'b000, 64'h1000, 12'd3, 64'h55, 5'd1, 64'h0000_0000_8000_0000, 0); // LB
    do_txn(1'b0, 3'b100, 64'h1000, 12'd3, 64'h55, 5'd2, 64'h0000_0000_8000_0000, 0); // LBU
    do_txn(1'b1, 3'b001, 64'h2000, 12'd6, 64'h1234, 5'd7, 64'd0, 1);                 // SH
    do_txn(1'b0, 3'b010, 64'h1000, 12'd2, 64'd0, 5'd3, 64'd0, 0);                     // LW misaligned
    do_txn(1'b0, 3'b110, 64'h100, 12'hFFC, 64'd0, 5'd4, 64'hDEAD_BEEF_0000_0000, 3); // LWU
    do_txn(1'b0, 3'b011, 64'h3008, 12'd0, 64'd0, 5'd0, 64'h0123_4567_89AB_CDEF, 1);  // LD rd=0
    do_txn(1'b0, 3'b011, 64'h3000, 12'd8, 64'd0, 5'd9, 64'h0123_4567_89AB_CDEF, 0);  // LD
    do_txn(1'b1, 3'b100, 64'h4000, 12'd0, 64'd0, 5'd1, 64'd0, 0);                     // illegal store
    do_txn(1'b0, 3'b111, 64'h4000, 12'd0, 64'd0, 5'd1, 64'd0, 0);                     // funct3 7
    do_txn(1'b1, 3'b011, 64'hFFFF_FFFF_FFFF_FFF8, 12'h010, 64'hA5A5_0F0F_1234_5678, 5'd5, 64'd0, 2); // SD wrap
    do_txn(1'b0, 3'b001, 64'h5000, 12'd6, 64'd0, 5'd6, 64'hFEDC_0000_0000_0000, 0); // LH signed

    // mem_ready outside ACCESS must not produce a response.
    mem_ready = 1'b1;
    @(posedge clock); #1;
    mem_ready = 1'b0;
    chk("idle_mem_ready_resp", {63'd0, resp_valid}, 64'd0);
    chk("idle_mem_ready_ce",   {63'd0, mem_chip_enable}, 64'd0);

    // Reset while waiting in ACCESS aborts the access.
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b011; req_base = 64'h6000;
    req_offset = 12'd0; req_rd = 5'd8;
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("pre_rst_ce", {63'd0, mem_chip_enable}, 64'd1);
    @(posedge clock); #1;
    #2 reset_neg = 1'b0;
    #1;
    chk("abort_ce",    {63'd0, mem_chip_enable}, 64'd0);
    chk("abort_ready", {63'd0, req_ready}, 64'd0);
    chk("abort_resp",  {63'd0, resp_valid}, 64'd0);
    chk("abort_be",    {56'd0, mem_byte_enable}, 64'd0);
    chk("abort_addr",  mem_address, 64'd0);
    mem_ready = 1'b1;
    @(posedge clock);
    #3 reset_neg = 1'b1;
    mem_ready = 1'b0;
    @(posedge clock); #1;
    chk("abort_ready_after", {63'd0, req_ready}, 64'd1);
    chk("abort_no_resp",     {63'd0, resp_valid}, 64'd0);

    // Randomized requests, mostly aligned.
    for (int i = 0; i < 40; i++) begin
      st   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      base = {$urandom, $urandom};
      off  = 12'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        ea   = base + {{52{off[11]}}, off};
        nb   = 1 << f3[1:0];
        base = base - (ea % nb);
      end
      do_txn(st, f3, base, off, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
             {$urandom, $urandom}, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
